// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared encodings, FSM states and lane helpers for mem_access_unit
// Purpose: funct3/size codes for loads and stores, the FSM state type, the bus timeout
//          limit and small helpers for offset truncation and misalignment detection.
// Ports:   none (package).
package mem_access_unit_pkg;

    localparam logic [7:0] TIMEOUT = 8'd255;

    // Load funct3 codes (bits[2:0] of mem_read_mem_in).
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Access sizes; store size codes share this encoding (SB/SH/SW).
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Collapse a raw 2-bit size field; anything that is not byte/half is a word.
    function automatic logic [1:0] norm_size(input logic [1:0] raw);
        logic [1:0] sz;
        case (raw)
            SZ_B:    sz = SZ_B;
            SZ_H:    sz = SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

    // Offset truncated to the natural alignment of the access size.
    function automatic logic [1:0] eff_offset(input logic [1:0] sz, input logic [1:0] off);
        logic [1:0] eo;
        case (sz)
            SZ_B:    eo = off;
            SZ_H:    eo = {off[1], 1'b0};
            default: eo = 2'b00;
        endcase
        return eo;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic mis;
        case (sz)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// rtl/mem_access_unit_load_extender.sv - load lane select plus sign/zero extension
// Purpose: pick the byte or half addressed by i_off out of a read word and extend it
//          according to the load funct3; unused codes pass the word through like LW.
// Ports:   i_funct3 (load type), i_off (byte offset, already truncated to size),
//          i_rdata (memory word), o_data (extended result).
module load_extender
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shifted = i_rdata >> {i_off, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory access controller
// Purpose: turns EX/MEM load/store controls into one req/ready transaction with byte
//          strobes, stalls the pipeline while it is outstanding and returns extended
//          load data. Optional macro MEM_MISALIGN_TRAP_EN: misaligned accesses skip the
//          bus and pulse misaligned_out; otherwise the offset is truncated to the size.
// Ports:   clk, rst (async active-low); mem_read_mem_in / mem_write_mem_in (controls),
//          alu_result_mem_in (address), read_data2_mem_in (store data);
//          dmem_req/we/addr/wdata/wstrb, dmem_ready/rdata (memory port);
//          load_data_out, mem_stall_out, bus_err_out, misaligned_out (pipeline side).
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mem_read_mem_in,
    input  logic [2:0]  mem_write_mem_in,
    input  logic [31:0] alu_result_mem_in,
    input  logic [31:0] read_data2_mem_in,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] load_data_out,
    output logic        mem_stall_out,
    output logic        bus_err_out,
    output logic        misaligned_out
);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic        r_is_load;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_load_data;
    logic        r_bus_err;
    logic        r_misaligned;

    logic        w_load;
    logic        w_store;
    logic        w_access;
    logic [1:0]  w_size;
    logic [1:0]  w_eff_off;
    logic        w_trap;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_ext;
    logic        w_capture;
    logic        w_complete;
    logic        w_timeout;
    logic        w_trap_hit;

    assign w_load   = mem_read_mem_in[3];
    assign w_store  = mem_write_mem_in[2];
    assign w_access = w_load | w_store;
    // Store has priority when both enables are set.
    assign w_size    = w_store ? norm_size(mem_write_mem_in[1:0]) : norm_size(mem_read_mem_in[1:0]);
    assign w_eff_off = eff_offset(w_size, alu_result_mem_in[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap = is_misaligned(w_size, alu_result_mem_in[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = 32'd0;
        if (w_store) begin
            case (w_size)
                SZ_B: begin
                    w_wstrb = 4'b0001 << w_eff_off;
                    w_wdata = {4{read_data2_mem_in[7:0]}};
                end
                SZ_H: begin
                    w_wstrb = 4'b0011 << w_eff_off;
                    w_wdata = {2{read_data2_mem_in[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = read_data2_mem_in;
                end
            endcase
        end
    end

    load_extender u_load_extender (
        .i_funct3 (r_funct3),
        .i_off    (r_off),
        .i_rdata  (dmem_rdata),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        w_trap_hit   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    if (w_trap) begin
                        w_trap_hit   = 1'b1;
                        w_state_next = ST_DONE;
                    end else begin
                        w_capture    = 1'b1;
                        w_state_next = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                // A ready in the last allowed cycle still wins over the timeout.
                if (dmem_ready) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_DONE;
                end else if (r_cnt == TIMEOUT - 8'd1) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= 8'd0;
            r_we         <= 1'b0;
            r_is_load    <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_wstrb      <= 4'b0000;
            r_funct3     <= 3'b000;
            r_off        <= 2'b00;
            r_load_data  <= 32'd0;
            r_bus_err    <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_bus_err    <= w_timeout;
            r_misaligned <= w_trap_hit;
            if (w_capture) begin
                r_cnt     <= 8'd0;
                r_we      <= w_store;
                r_is_load <= ~w_store;
                r_addr    <= {alu_result_mem_in[31:2], 2'b00};
                r_wdata   <= w_wdata;
                r_wstrb   <= w_wstrb;
                r_funct3  <= mem_read_mem_in[2:0];
                r_off     <= w_eff_off;
            end else if (r_state == ST_ACCESS) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_complete && r_is_load) r_load_data <= w_ext;
            else if (w_timeout || w_trap_hit) r_load_data <= 32'd0;
        end
    end

    assign dmem_req       = (r_state == ST_ACCESS);
    assign dmem_we        = r_we;
    assign dmem_addr      = r_addr;
    assign dmem_wdata     = r_wdata;
    assign dmem_wstrb     = r_wstrb;
    assign load_data_out  = r_load_data;
    assign bus_err_out    = r_bus_err;
    assign misaligned_out = r_misaligned;
    // Gated by rst so the pipeline is never frozen while held in reset.
    assign mem_stall_out  = rst & (((r_state == ST_IDLE) & w_access) | (r_state == ST_ACCESS));

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  mem_read_mem_in = 4'h0;
    logic [2:0]  mem_write_mem_in = 3'h0;
    logic [31:0] alu_result_mem_in = 32'h0;
    logic [31:0] read_data2_mem_in = 32'h0;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_req, dmem_we, mem_stall_out, bus_err_out, misaligned_out;
    logic [31:0] dmem_addr, dmem_wdata, load_data_out;
    logic [3:0]  dmem_wstrb;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .mem_read_mem_in(mem_read_mem_in), .mem_write_mem_in(mem_write_mem_in),
        .alu_result_mem_in(alu_result_mem_in), .read_data2_mem_in(read_data2_mem_in),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .load_data_out(load_data_out), .mem_stall_out(mem_stall_out),
        .bus_err_out(bus_err_out), .misaligned_out(misaligned_out)
    );

    typedef struct {
        string       name;
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waitc;
        bit          exp_req;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
        int          exp_stall;
        bit          exp_err;
        bit          exp_mis;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [3:0] rd, input logic [2:0] wr,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input int waitc, input bit exp_req, input logic [31:0] exp_addr,
                       input logic exp_we, input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                       input logic [31:0] exp_load, input int exp_stall, input bit exp_err,
                       input bit exp_mis);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.waitc = waitc; v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_we = exp_we;
        v.exp_wstrb = exp_wstrb; v.exp_wdata = exp_wdata; v.exp_load = exp_load;
        v.exp_stall = exp_stall; v.exp_err = exp_err; v.exp_mis = exp_mis;
        vecs.push_back(v);
    endtask

    // Drives one access from IDLE, acts as the memory, and checks the whole transaction.
    task automatic run_vec(input vec_t v);
        int   stall_cnt;
        int   acc;
        bit   done;
        bit   have_exp;
        vec_t e;
        stall_cnt = 0; acc = 0; done = 0; have_exp = 0;
        @(negedge clk);
        mem_read_mem_in   = v.rd;
        mem_write_mem_in  = v.wr;
        alu_result_mem_in = v.addr;
        read_data2_mem_in = v.wdata;
        dmem_rdata        = v.rdata;
        dmem_ready        = 1'b0;
        if (v.exp_req) sb_q.push_back(v);
        for (int c = 0; c < 400 && !done; c++) begin
            #1;
            if (mem_stall_out) begin
                stall_cnt++;
                if (dmem_req) begin
                    if (!have_exp) begin
                        if (sb_q.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL %s_unexpected_req actual=1 expected=0", v.name);
                        end else begin
                            e = sb_q.pop_front();
                            have_exp = 1;
                            chk({v.name, "_we"}, {31'd0, dmem_we}, {31'd0, e.exp_we});
                            chk({v.name, "_wstrb"}, {28'd0, dmem_wstrb}, {28'd0, e.exp_wstrb});
                            if (e.exp_we) chk({v.name, "_wdata"}, dmem_wdata, e.exp_wdata);
                        end
                    end
                    if (have_exp) chk({v.name, "_addr"}, dmem_addr, e.exp_addr);
                    acc++;
                    dmem_ready = (acc == v.waitc + 1);
                end
            end else if (c > 0) begin
                done = 1;
            end
            if (!done) begin
                @(negedge clk);
                mem_read_mem_in  = 4'h0;
                mem_write_mem_in = 3'h0;
                dmem_ready       = 1'b0;
            end
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s_timeout_budget actual=running expected=done", v.name);
        end
        if (v.exp_req && !have_exp) begin
            checks++; failures++;
            $display("FAIL %s_missing_req actual=0 expected=1", v.name);
            void'(sb_q.pop_front());
        end
        chk({v.name, "_stall"}, stall_cnt, v.exp_stall);
        chk({v.name, "_load"}, load_data_out, v.exp_load);
        chk({v.name, "_bus_err"}, {31'd0, bus_err_out}, {31'd0, v.exp_err});
        chk({v.name, "_misaligned"}, {31'd0, misaligned_out}, {31'd0, v.exp_mis});
        chk({v.name, "_req_done"}, {31'd0, dmem_req}, 32'd0);
    endtask

    initial begin
        //  name     rd     wr      addr    wdata         rdata         wait req exp_addr   we strb exp_wdata     load          stall err mis
        add("sw",    4'h0, 3'b110, 32'h100, 32'hDEADBEEF, 32'h0,        0,   1, 32'h100, 1, 4'hF, 32'hDEADBEEF, 32'h0,        2,   0, 0);
        add("sb",    4'h0, 3'b100, 32'h103, 32'h000000A5, 32'h0,        1,   1, 32'h100, 1, 4'h8, 32'hA5A5A5A5, 32'h0,        3,   0, 0);
        add("lb",    4'h8, 3'b000, 32'h202, 32'h0,        32'h0080FF00, 3,   1, 32'h200, 0, 4'h0, 32'h0,        32'hFFFFFF80, 5,   0, 0);
        add("lbu",   4'hC, 3'b000, 32'h202, 32'h0,        32'h0080FF00, 3,   1, 32'h200, 0, 4'h0, 32'h0,        32'h00000080, 5,   0, 0);
        add("lh",    4'h9, 3'b000, 32'h202, 32'h0,        32'h80010000, 0,   1, 32'h200, 0, 4'h0, 32'h0,        32'hFFFF8001, 2,   0, 0);
        add("lhu",   4'hD, 3'b000, 32'h006, 32'h0,        32'h9ABC1234, 1,   1, 32'h004, 0, 4'h0, 32'h0,        32'h00009ABC, 3,   0, 0);
        add("lw",    4'hA, 3'b000, 32'h00C, 32'h0,        32'h12345678, 2,   1, 32'h00C, 0, 4'h0, 32'h0,        32'h12345678, 4,   0, 0);
        add("sh",    4'h0, 3'b101, 32'h012, 32'h1234BEEF, 32'h0,        0,   1, 32'h010, 1, 4'hC, 32'hBEEFBEEF, 32'h12345678, 2,   0, 0);
        add("ldst",  4'hA, 3'b101, 32'h020, 32'h0000CAFE, 32'hFFFFFFFF, 0,   1, 32'h020, 1, 4'h3, 32'hCAFECAFE, 32'h12345678, 2,   0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        add("lh_mis",4'h9, 3'b000, 32'h001, 32'h0,        32'h1234F00D, 0,   0, 32'h0,   0, 4'h0, 32'h0,        32'h00000000, 1,   0, 1);
`else
        add("lh_mis",4'h9, 3'b000, 32'h001, 32'h0,        32'h1234F00D, 0,   1, 32'h000, 0, 4'h0, 32'h0,        32'hFFFFF00D, 2,   0, 0);
`endif
        add("f3_011",4'hB, 3'b000, 32'h030, 32'h0,        32'h0BADF00D, 0,   1, 32'h030, 0, 4'h0, 32'h0,        32'h0BADF00D, 2,   0, 0);
        add("lb_pos",4'h8, 3'b000, 32'h001, 32'h0,        32'h00007F00, 0,   1, 32'h000, 0, 4'h0, 32'h0,        32'h0000007F, 2,   0, 0);
        add("tmo",   4'hA, 3'b000, 32'h040, 32'h0,        32'h0,        1000,1, 32'h040, 0, 4'h0, 32'h0,        32'h00000000, 256, 1, 0);
        add("sw2",   4'h0, 3'b110, 32'h044, 32'h01020304, 32'h0,        0,   1, 32'h044, 1, 4'hF, 32'h01020304, 32'h00000000, 2,   0, 0);

        // Reset state, with a load request present to show the stall stays low in reset.
        mem_read_mem_in = 4'hA;
        #3;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
        chk("rst_load", load_data_out, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err_out}, 32'd0);
        chk("rst_mis", {31'd0, misaligned_out}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall_out}, 32'd0);
        mem_read_mem_in = 4'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while a load is outstanding.
        @(negedge clk);
        mem_read_mem_in   = 4'hA;
        alu_result_mem_in = 32'h050;
        dmem_ready        = 1'b0;
        @(negedge clk);
        mem_read_mem_in = 4'h0;
        @(negedge clk);
        #1;
        chk("midrst_req_before", {31'd0, dmem_req}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_req_async", {31'd0, dmem_req}, 32'd0);
        chk("midrst_stall_async", {31'd0, mem_stall_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_idle_req", {31'd0, dmem_req}, 32'd0);
        chk("midrst_idle_stall", {31'd0, mem_stall_out}, 32'd0);
        chk("midrst_no_completion", {31'd0, bus_err_out}, 32'd0);
        begin
            vec_t v;
            v.name = "lw_after_rst"; v.rd = 4'hA; v.wr = 3'b000; v.addr = 32'h060;
            v.wdata = 32'h0; v.rdata = 32'h55AA55AA; v.waitc = 0; v.exp_req = 1;
            v.exp_addr = 32'h060; v.exp_we = 0; v.exp_wstrb = 4'h0; v.exp_wdata = 32'h0;
            v.exp_load = 32'h55AA55AA; v.exp_stall = 2; v.exp_err = 0; v.exp_mis = 0;
            run_vec(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access controller. It consumes the load/store controls, ALU address and store data latched by the EX/MEM pipeline register. It drives a req/ready data-memory port with byte strobes, stalls the pipeline while an access is outstanding, and returns sign- or zero-extended load data to the MEM/WB path.

## Interface
- TIMEOUT, 255: max cycles to wait for dmem_ready before aborting with bus_err (8-bit counter).
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-low reset
- mem_read_mem_in  input  4  bit3 = load enable; bits[2:0] = funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101)
- mem_write_mem_in  input  3  bit2 = store enable; bits[1:0] = size (SB 00, SH 01, SW 10)
- alu_result_mem_in  input  32  byte address
- read_data2_mem_in  input  32  store data (right-aligned)
- dmem_ready  input  1  memory completes the current request this cycle
- dmem_rdata  input  32  word read data, valid with dmem_ready
- dmem_req  output  1  request valid
- dmem_we  output  1  1 = write
- dmem_addr  output  32  word address (bits[1:0] = 0)
- dmem_wdata  output  32  lane-shifted store data
- dmem_wstrb  output  4  byte-lane enables (0 for reads)
- load_data_out  output  32  extended load result
- mem_stall_out  output  1  freeze IF..EX/MEM registers
- bus_err_out  output  1  one-cycle pulse on timeout
- misaligned_out  output  1  one-cycle pulse (feature-dependent)

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: an access is a load (rd[3]) or a store (wr[2]). If both are set, the store wins. On an access:
  - mem_stall_out is asserted combinationally in the same cycle.
  - The request is captured into registers: addr, byte offset, funct3/size, shifted wdata, wstrb.
  - The FSM moves to ACCESS and the timeout counter is cleared.
- ACCESS: dmem_req = 1, with addr/we/wdata/wstrb driven from the captured registers and held stable.
  - dmem_ready = 1: a load latches the extracted and extended data into load_data_out. Go to DONE.
  - Counter reaches TIMEOUT: pulse bus_err_out, set load_data_out = 0, go to DONE.
- DONE: mem_stall_out = 0 for one cycle so the pipeline advances, then return to IDLE. A new access in this cycle is not sampled; it is sampled in IDLE next cycle.
- Lane rules (off = addr[1:0]):
  - SB: wstrb = 0001 << off, wdata = {4{byte}}.
  - SH: wstrb = 0011 << off, wdata = {2{half}}.
  - SW: wstrb = 1111.
  - Loads: select the byte/half at off, then sign-extend (LB/LH) or zero-extend (LBU/LHU). LW passes through.
- Misalignment means a half access with off[0] = 1, or a word access with off ≠ 0.
- Unused read funct3 codes (011, 110, 111) are treated as LW.
- dmem_req stays high from ACCESS entry until the ready/timeout cycle. dmem_req is never 1 in IDLE or DONE.

## Timing
- Reset values (async, rst low): state IDLE; dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata = 0; load_data_out = 0; bus_err_out, misaligned_out = 0; counter = 0.
- mem_stall_out is 0 in reset. Outside reset it is combinational: it follows any access seen in IDLE.
- Latency: N = number of ACCESS cycles, N ≥ 1. If dmem_ready arrives in the first ACCESS cycle, the stall lasts 2 cycles (IDLE detect + ACCESS) and load_data_out is valid in DONE.
- Load data and the pulse outputs update on the same edge that enters DONE. load_data_out holds until the next load completes.
- Reset mid-access: dmem_req drops immediately (asynchronous). No completion is reported.
- Timeout: bus_err_out is high in the DONE cycle only.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned access in IDLE skips ACCESS and goes directly to DONE.
  - misaligned_out pulses in DONE. No dmem_req is issued and load_data_out = 0.
- MEM_MISALIGN_TRAP_EN undefined:
  - The offset is truncated to the access size (half uses off & 2, word uses 0) and the access proceeds normally.
  - misaligned_out is tied to 0.

## Structure
- Shared package/include holds `LB/`LH/`LW/`LBU/`LHU, `SB/`SH/`SW and the FSM state constants, alongside the existing encodings include.
- One sub-module, load_extender: combinational lane select plus sign/zero extension, unit-testable on its own.

## Test plan
- SW at 0x100, data 0xDEADBEEF, ready on the 1st ACCESS cycle -> dmem_addr 0x100, wstrb 1111, wdata 0xDEADBEEF; stall high exactly 2 cycles.
- SB at 0x103, data 0x000000A5 -> wstrb 1000, wdata 0xA5A5A5A5.
- LB at 0x202, rdata 0x0080FF00, ready after 3 wait cycles -> load_data_out 0xFFFFFF80; stall 5 cycles. The same access as LBU -> 0x00000080.
- LH at 0x001:
  - with MEM_MISALIGN_TRAP_EN -> no dmem_req, misaligned_out pulse, stall 1 cycle.
  - without it -> access at 0x000 with the lower half selected.
- dmem_ready held 0 -> bus_err_out pulses after 255 ACCESS cycles; load_data_out = 0; stall then releases.
- rst driven low mid-ACCESS -> dmem_req = 0 immediately; state IDLE after release; the next LW completes normally.
